// File: rtl/slow_clk_pkg.sv
// Shared constants and the ratio clamp for the slow-clock generator.
package slow_clk_pkg;

   localparam int DIV_MIN         = 2;
   localparam int DEFAULT_DIV_40K = 1000;

   // A ratio below 2 cannot produce both a high and a low phase.
   function automatic logic [31:0] f_clamp_div(input logic [31:0] d);
      return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
   endfunction

endpackage

// File: rtl/slow_clock_channel.sv
// One divider channel: counter, live/pending ratio, registered clk_out and tick.
// Outputs lag cnt by one cycle; a new ratio waits (pending) until a period boundary, disable or sync.
module slow_clock_channel
   import slow_clk_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_40K
) (
   input  logic             clk40M,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] pend_div;
   logic [DIV_W-1:0] last_cnt;
   logic [DIV_W-1:0] high_from;
   logic             boundary;
   logic             apply;

   assign last_cnt  = div - DIV_W'(1);
   assign high_from = div - (div >> 1);
   assign boundary  = (cnt == last_cnt);
   // Swapping only at these points keeps every period whole under one ratio.
   assign apply     = pending & (~en | sync | boundary);

   always_ff @(posedge clk40M or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!en || sync || boundary) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk40M or posedge rst) begin
      if (rst) begin
         div      <= DIV_W'(DEFAULT_DIV);
         pend_div <= '0;
         pending  <= 1'b0;
      end else if (apply) begin
         div     <= pend_div;
         pending <= 1'b0;
      end else if (wr) begin
         pend_div <= wr_div;
         pending  <= 1'b1;
      end
   end

   always_ff @(posedge clk40M or posedge rst) begin
      if (rst) begin
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else begin
         clk_out <= en & (cnt >= high_from);
         tick    <= en & boundary;
      end
   end

endmodule

// File: rtl/multi_slow_clock_generator.sv
// N-channel programmable slow-clock/tick generator with glitch-free ratio updates and common sync.
// Ratio writes use valid/ready; a channel is not ready while its previous write is still pending.
module multi_slow_clock_generator
   import slow_clk_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = DEFAULT_DIV_40K,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk40M,
   input  logic             rst,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             sync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic [N_CH-1:0]  clk_out,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pending
);

   localparam int PAD_W = 1 << CH_W;

   logic [PAD_W-1:0] pend_pad;
   logic [DIV_W-1:0] wr_div;
   logic             accept;

   // Unused channel codes read as "not pending", so such writes are accepted and dropped.
   assign pend_pad  = PAD_W'(pending);
   assign cfg_ready = ~pend_pad[cfg_ch];
   assign accept    = cfg_valid & cfg_ready;
   assign wr_div    = DIV_W'(f_clamp_div(32'(cfg_div)));

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      slow_clock_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk40M  (clk40M),
         .rst     (rst),
         .en      (ch_en[i]),
         .sync    (sync),
         .wr      (accept && (cfg_ch == CH_W'(i))),
         .wr_div  (wr_div),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (pending[i])
      );
   end

endmodule

// File: tb/tb_multi_slow_clock_generator.sv
// Directed bench for multi_slow_clock_generator; five channels so channel code 7 is out of range.
module tb_multi_slow_clock_generator;

   localparam int N_CH  = 5;
   localparam int DIV_W = 16;
   localparam int CH_W  = 3;

   logic             clk40M = 1'b0;
   logic             rst;
   logic [N_CH-1:0]  ch_en;
   logic             sync;
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [N_CH-1:0]  clk_out;
   logic [N_CH-1:0]  tick;
   logic [N_CH-1:0]  pending;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      int div_in;
      int period;
      int high;
   } vec_t;

   vec_t tbl[6];

   multi_slow_clock_generator #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (1000)
   ) dut (
      .clk40M    (clk40M),
      .rst       (rst),
      .ch_en     (ch_en),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .clk_out   (clk_out),
      .tick      (tick),
      .pending   (pending)
   );

   always #5 clk40M = ~clk40M;

   task automatic step();
      @(posedge clk40M);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

   initial begin
      int first_a, first_b, first_c, cnt_a, hi, found, rises, tk;
      logic prev;
      logic [9:0] cb, tbits;

      tbl[0] = '{0, 2, 1};
      tbl[1] = '{1, 2, 1};
      tbl[2] = '{2, 2, 1};
      tbl[3] = '{5, 5, 2};
      tbl[4] = '{7, 7, 3};
      tbl[5] = '{4, 4, 2};

      rst = 1'b1; ch_en = 5'b00011; sync = 1'b0;
      cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
      step(); step();
      chk("reset_clk_out", int'(clk_out), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_pending", int'(pending), 0);
      chk("reset_cfg_ready", int'(cfg_ready), 1);
      rst = 1'b0;

      // Default ratio 1000 from reset release
      first_a = 0; first_b = 0; first_c = 0; cnt_a = 0; hi = 0;
      for (int k = 1; k <= 2000; k++) begin
         step();
         if (tick[0]) begin
            cnt_a++;
            if (first_a == 0) first_a = k;
            else if (first_b == 0) first_b = k;
         end
         if (clk_out[0] && first_c == 0) first_c = k;
         if (clk_out[0] && k <= 1000) hi++;
      end
      chk("t1_first_tick", first_a, 1000);
      chk("t1_second_tick", first_b, 2000);
      chk("t1_tick_count", cnt_a, 2);
      chk("t1_first_high", first_c, 501);
      chk("t1_high_cycles", hi, 500);

      // Mid-period write of 5 to ch1 (cnt=300)
      repeat (300) step();
      cfg_ch = 3'd1; cfg_div = 16'd5; cfg_valid = 1'b1;
      #1;
      chk("t2_ready_before", int'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
      #1;
      chk("t2_pending_set", int'(pending[1]), 1);
      chk("t2_ready_blocked", int'(cfg_ready), 0);
      found = 0; rises = 0; tk = 0; prev = clk_out[1];
      for (int k = 1; k <= 1000; k++) begin
         step();
         if (clk_out[1] && !prev) rises++;
         prev = clk_out[1];
         if (!pending[1]) begin
            found = k;
            tk = int'(tick[1]);
            break;
         end
      end
      chk("t2_apply_cycle", found, 699);
      chk("t2_boundary_tick", tk, 1);
      chk("t2_rises_while_pending", rises, 1);
      for (int j = 0; j < 10; j++) begin
         step();
         cb[j] = clk_out[1];
         tbits[j] = tick[1];
      end
      chk("t2_clk_pattern", int'(cb), int'(10'b1100011000));
      chk("t2_tick_pattern", int'(tbits), int'(10'b1000010000));

      // Ratio table on ch2: write while disabled, then run two periods
      for (int e = 0; e < 6; e++) begin
         cfg_ch = 3'd2; cfg_div = DIV_W'(tbl[e].div_in); cfg_valid = 1'b1;
         step();
         cfg_valid = 1'b0;
         chk("t3_pending_set", int'(pending[2]), 1);
         step();
         chk("t3_applied_when_off", int'(pending[2]), 0);
         ch_en[2] = 1'b1;
         first_a = 0; first_c = 0; hi = 0;
         for (int j = 1; j <= 2 * tbl[e].period; j++) begin
            step();
            if (tick[2] && first_a == 0) first_a = j;
            if (clk_out[2] && first_c == 0) first_c = j;
            if (clk_out[2]) hi++;
         end
         chk("t3_first_tick", first_a, tbl[e].period);
         chk("t3_first_high", first_c, tbl[e].period - tbl[e].high + 1);
         chk("t3_high_cycles", hi, 2 * tbl[e].high);
         ch_en[2] = 1'b0;
         step();
         chk("t3_off_outputs", int'({clk_out[2], tick[2]}), 0);
      end

      // ch0 ratio 7, ch2 ratio 11 (pending at sync), common sync
      cfg_ch = 3'd0; cfg_div = 16'd7; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      found = 0;
      for (int k = 1; k <= 1100; k++) begin
         step();
         if (!pending[0]) begin
            found = 1;
            break;
         end
      end
      chk("t4_ch0_applied", found, 1);
      cfg_ch = 3'd2; cfg_div = 16'd1000; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      ch_en[2] = 1'b1;
      repeat (5) step();
      cfg_div = 16'd11; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("t4_ch2_pending", int'(pending[2]), 1);
      sync = 1'b1;
      step();
      sync = 1'b0;
      chk("t4_sync_applies", int'(pending[2]), 0);
      first_a = 0; first_b = 0; first_c = 0;
      for (int j = 1; j <= 100; j++) begin
         step();
         if (tick[0] && first_a == 0) first_a = j;
         if (tick[2] && first_b == 0) first_b = j;
         if (tick[0] && tick[2] && first_c == 0) first_c = j;
      end
      chk("t4_ch0_first_tick", first_a, 7);
      chk("t4_ch2_first_tick", first_b, 11);
      chk("t4_coincide", first_c, 77);

      // ch3 disabled mid-period, then re-enabled
      ch_en[3] = 1'b1;
      repeat (300) step();
      ch_en[3] = 1'b0;
      step();
      chk("t5_off_clk", int'(clk_out[3]), 0);
      chk("t5_off_tick", int'(tick[3]), 0);
      cnt_a = 0;
      for (int j = 0; j < 1100; j++) begin
         step();
         if (tick[3] || clk_out[3]) cnt_a++;
      end
      chk("t5_silent_while_off", cnt_a, 0);
      ch_en[3] = 1'b1;
      first_a = 0; first_c = 0;
      for (int j = 1; j <= 1000; j++) begin
         step();
         if (tick[3] && first_a == 0) first_a = j;
         if (clk_out[3] && first_c == 0) first_c = j;
      end
      chk("t5_full_period_tick", first_a, 1000);
      chk("t5_full_period_high", first_c, 501);

      // Reset during a pending write, then a write to an unused channel code
      cfg_ch = 3'd3; cfg_div = 16'd9; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      chk("t6_pending_before_rst", int'(pending[3]), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_pending", int'(pending), 0);
      chk("t6_async_outputs", int'({clk_out, tick}), 0);
      step();
      ch_en = 5'b01001;
      cfg_ch = 3'd7; cfg_div = 16'd3; cfg_valid = 1'b1;
      #1;
      chk("t6_unused_ready", int'(cfg_ready), 1);
      rst = 1'b0;
      first_a = 0; first_b = 0;
      for (int j = 1; j <= 1000; j++) begin
         step();
         if (j == 1) begin
            cfg_valid = 1'b0;
            chk("t6_unused_no_pending", int'(pending), 0);
         end
         if (tick[0] && first_a == 0) first_a = j;
         if (tick[3] && first_b == 0) first_b = j;
      end
      chk("t6_ch0_default_div", first_a, 1000);
      chk("t6_ch3_default_div", first_b, 1000);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
